// File: rtl/npc_pc_gen_if.sv
// Fetch/branch/trap bundle between the execute, CSR and fetch stages and the PC generator.
// Master drives the resolution inputs and fetch-ready; slave is the PC generator.
interface npc_pc_gen_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic              br_valid;
    logic [7:0]        br_type;
    logic [2:0]        br_cmp;
    logic [XLEN-1:0]   br_pc;
    logic [XLEN-1:0]   br_src1;
    logic [XLEN-1:0]   br_imm;
    logic              trap_valid;
    logic [XLEN-1:0]   trap_target;
    logic              if_ready;
    logic [XLEN-1:0]   pc_out;
    logic              pc_valid;
    logic [XLEN-1:0]   link_data;
    logic              redirect;
    logic              misalign_valid;
    logic [XLEN-1:0]   misalign_addr;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output br_valid, br_type, br_cmp, br_pc, br_src1, br_imm,
               trap_valid, trap_target, if_ready,
        input  pc_out, pc_valid, link_data, redirect,
               misalign_valid, misalign_addr, redirect_cnt
    );

    modport slave (
        input  br_valid, br_type, br_cmp, br_pc, br_src1, br_imm,
               trap_valid, trap_target, if_ready,
        output pc_out, pc_valid, link_data, redirect,
               misalign_valid, misalign_addr, redirect_cnt
    );
endinterface

// File: rtl/npc_pc_gen.sv
// Registered PC generator: sequential fetch prediction plus branch/jump/trap redirect
// with misalignment reporting and a saturating redirect counter.
module npc_pc_gen #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          INST_BYTES = 4,
    parameter int          CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    npc_pc_gen_if.slave   bus
);
    localparam logic [XLEN-1:0] RST_PC     = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] BIT0       = XLEN'(1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q;
    logic             redirect_q, redirect_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  mis_addr_q, mis_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             taken;
    logic             aligned;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  br_tgt;

    // Zero or multi-hot br_type falls to the default and is never taken.
    always_comb begin
        taken = 1'b0;
        unique case (bus.br_type)
            8'b0000_0001: taken = 1'b1;
            8'b0000_0010: taken = 1'b1;
            8'b0000_0100: taken = bus.br_cmp[0];
            8'b0000_1000: taken = ~bus.br_cmp[0];
            8'b0001_0000: taken = ~bus.br_cmp[1];
            8'b0010_0000: taken = ~bus.br_cmp[2];
            8'b0100_0000: taken = bus.br_cmp[1];
            8'b1000_0000: taken = bus.br_cmp[2];
            default:      taken = 1'b0;
        endcase
    end

    always_comb begin
        jalr_sum   = bus.br_src1 + bus.br_imm;
        br_tgt     = bus.br_type[1] ? (jalr_sum & ~BIT0) : (bus.br_pc + bus.br_imm);
        aligned    = (br_tgt & ALIGN_MASK) == '0;

        redirect_d = bus.trap_valid | (bus.br_valid & taken & aligned);
        mis_d      = ~bus.trap_valid & bus.br_valid & taken & ~aligned;
        mis_addr_d = mis_d ? br_tgt : mis_addr_q;

        pc_d = pc_q;
        if (bus.trap_valid)
            pc_d = bus.trap_target;
        else if (redirect_d)
            pc_d = br_tgt;
        else if (valid_q && bus.if_ready)
            pc_d = pc_q + STEP;

        cnt_d = cnt_q;
        if (redirect_d && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RST_PC;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            redirect_q <= redirect_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.pc_valid       = valid_q;
    assign bus.redirect       = redirect_q;
    assign bus.misalign_valid = mis_q;
    assign bus.misalign_addr  = mis_addr_q;
    assign bus.redirect_cnt   = cnt_q;
    assign bus.link_data      = bus.br_pc + STEP;
endmodule
